// File: rtl/ahb_mem_arbiter_if.sv
// ============================================================================
// ahb_mem_arbiter_if : bus bundle between AHB-lite masters, arbiter and memory
// Revision 1.0
// ============================================================================
`default_nettype none

interface ahb_mem_arbiter_if #(
    parameter int N_MASTERS = 2,
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 32
);
    logic [2*N_MASTERS-1:0]      m_htrans;
    logic [W_ADDR*N_MASTERS-1:0] m_haddr;
    logic [N_MASTERS-1:0]        m_hwrite;
    logic [3*N_MASTERS-1:0]      m_hsize;
    logic [N_MASTERS-1:0]        m_hexcl;
    logic [N_MASTERS-1:0]        m_hmastlock;
    logic [W_DATA*N_MASTERS-1:0] m_hwdata;
    logic [N_MASTERS-1:0]        m_hready;
    logic [W_DATA*N_MASTERS-1:0] m_hrdata;
    logic [N_MASTERS-1:0]        m_hresp;
    logic [N_MASTERS-1:0]        m_hexokay;

    logic [1:0]        s_htrans;
    logic [W_ADDR-1:0] s_haddr;
    logic              s_hwrite;
    logic [2:0]        s_hsize;
    logic              s_hexcl;
    logic              s_hmastlock;
    logic [W_DATA-1:0] s_hwdata;
    logic              s_hready;
    logic [7:0]        s_hmaster;
    logic              s_hready_resp;
    logic [W_DATA-1:0] s_hrdata;
    logic              s_hresp;
    logic              s_hexokay;

    logic              proto_err;

    // Arbiter side
    modport slave (
        input  m_htrans, m_haddr, m_hwrite, m_hsize, m_hexcl, m_hmastlock, m_hwdata,
        output m_hready, m_hrdata, m_hresp, m_hexokay,
        output s_htrans, s_haddr, s_hwrite, s_hsize, s_hexcl, s_hmastlock, s_hwdata,
        output s_hready, s_hmaster,
        input  s_hready_resp, s_hrdata, s_hresp, s_hexokay,
        output proto_err
    );

    // Environment side: masters plus the memory slave
    modport master (
        output m_htrans, m_haddr, m_hwrite, m_hsize, m_hexcl, m_hmastlock, m_hwdata,
        input  m_hready, m_hrdata, m_hresp, m_hexokay,
        input  s_htrans, s_haddr, s_hwrite, s_hsize, s_hexcl, s_hmastlock, s_hwdata,
        input  s_hready, s_hmaster,
        output s_hready_resp, s_hrdata, s_hresp, s_hexokay,
        input  proto_err
    );
endinterface

`default_nettype wire

// File: rtl/ahb_mem_arbiter.sv
// ============================================================================
// ahb_mem_arbiter : N-master AHB-lite to single memory slave, round-robin + lock
// Revision 1.0
// ============================================================================
`default_nettype none

module ahb_mem_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    ahb_mem_arbiter_if.slave  bus
);
    localparam int         IDX_W       = (N_MASTERS > 2) ? 2 : 1;
    localparam logic [1:0] c_HT_IDLE   = 2'b00;
    localparam logic [1:0] c_HT_BUSY   = 2'b01;
    localparam logic [1:0] c_HT_NONSEQ = 2'b10;
    localparam logic [1:0] c_HT_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                state_q;
    logic [N_MASTERS-1:0]  pend_q;
    logic [W_ADDR-1:0]     haddr_q     [N_MASTERS];
    logic [2:0]            hsize_q     [N_MASTERS];
    logic [N_MASTERS-1:0]  hwrite_q;
    logic [N_MASTERS-1:0]  hexcl_q;
    logic [N_MASTERS-1:0]  hmastlock_q;
    logic [IDX_W-1:0]      grant_q;
    logic [IDX_W-1:0]      last_grant_q;
    logic                  lock_q;
    logic [IDX_W-1:0]      lock_mst_q;
    logic                  proto_err_q;

    logic [N_MASTERS-1:0]  hready;
    logic [N_MASTERS-1:0]  cap;
    logic [N_MASTERS-1:0]  bad;
    logic [N_MASTERS-1:0]  req;
    logic [N_MASTERS-1:0]  clr;
    logic [N_MASTERS-1:0]  pend_d;
    logic [IDX_W-1:0]      win;
    logic                  found;
    int                    idx;
    logic                  busy;
    logic                  complete;

    logic [W_ADDR-1:0]     sel_addr;
    logic                  sel_write;
    logic [2:0]            sel_size;
    logic                  sel_excl;
    logic                  sel_lock;
    logic [W_DATA-1:0]     sel_wdata;

    assign busy     = (state_q != ST_IDLE);
    assign complete = (state_q == ST_DATA) && bus.s_hready_resp;

    always_comb begin
        hready = '1;
        cap    = '0;
        bad    = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (pend_q[i] || (busy && grant_q == IDX_W'(i)))
                hready[i] = 1'b0;
            if (complete && grant_q == IDX_W'(i))
                hready[i] = 1'b1;
            cap[i] = hready[i] && (bus.m_htrans[2*i +: 2] == c_HT_NONSEQ);
            bad[i] = hready[i] && ((bus.m_htrans[2*i +: 2] == c_HT_BUSY) ||
                                   (bus.m_htrans[2*i +: 2] == c_HT_SEQ));
        end
    end

    // Requests captured this cycle are eligible so a lone request reaches ADDR next cycle
    assign req    = pend_q | cap;
    assign clr    = (state_q == ST_ADDR) ? (N_MASTERS'(1) << grant_q) : '0;
    assign pend_d = (pend_q & ~clr) | cap;

    always_comb begin
        win   = last_grant_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            idx = (int'(last_grant_q) + k) % N_MASTERS;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
        if (lock_q && req[lock_mst_q])
            win = lock_mst_q;
    end

    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_size  = '0;
        sel_excl  = 1'b0;
        sel_lock  = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_addr  = haddr_q[i];
                sel_write = hwrite_q[i];
                sel_size  = hsize_q[i];
                sel_excl  = hexcl_q[i];
                sel_lock  = hmastlock_q[i];
                sel_wdata = bus.m_hwdata[W_DATA*i +: W_DATA];
            end
        end
    end

    always_comb begin
        bus.m_hready  = hready;
        bus.m_hrdata  = '0;
        bus.m_hresp   = '0;
        bus.m_hexokay = '1;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (state_q == ST_DATA && grant_q == IDX_W'(i)) begin
                bus.m_hrdata[W_DATA*i +: W_DATA] = bus.s_hrdata;
                bus.m_hresp[i]                   = bus.s_hresp;
                bus.m_hexokay[i]                 = bus.s_hexokay;
            end
        end
        bus.s_htrans    = (state_q == ST_ADDR) ? c_HT_NONSEQ : c_HT_IDLE;
        bus.s_haddr     = sel_addr;
        bus.s_hwrite    = sel_write;
        bus.s_hsize     = sel_size;
        bus.s_hexcl     = sel_excl;
        bus.s_hmastlock = sel_lock;
        bus.s_hwdata    = (state_q == ST_DATA) ? sel_wdata : '0;
        bus.s_hready    = bus.s_hready_resp;
        bus.s_hmaster   = 8'(grant_q);
        bus.proto_err   = proto_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            hwrite_q     <= '0;
            hexcl_q      <= '0;
            hmastlock_q  <= '0;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(N_MASTERS - 1);
            lock_q       <= 1'b0;
            lock_mst_q   <= '0;
            proto_err_q  <= 1'b0;
            for (int i = 0; i < N_MASTERS; i++) begin
                haddr_q[i] <= '0;
                hsize_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            if (|bad)
                proto_err_q <= 1'b1;
            for (int i = 0; i < N_MASTERS; i++) begin
                if (cap[i]) begin
                    haddr_q[i]     <= bus.m_haddr[W_ADDR*i +: W_ADDR];
                    hsize_q[i]     <= bus.m_hsize[3*i +: 3];
                    hwrite_q[i]    <= bus.m_hwrite[i];
                    hexcl_q[i]     <= bus.m_hexcl[i];
                    hmastlock_q[i] <= bus.m_hmastlock[i];
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (|req && bus.s_hready_resp) begin
                        state_q      <= ST_ADDR;
                        grant_q      <= win;
                        last_grant_q <= win;
                    end
                end
                ST_ADDR: state_q <= ST_DATA;
                ST_DATA: begin
                    // Lock follows the most recently completed transfer
                    if (bus.s_hready_resp) begin
                        state_q    <= ST_IDLE;
                        lock_q     <= sel_lock;
                        lock_mst_q <= grant_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_ahb_mem_arbiter.sv
// ============================================================================
// tb_ahb_mem_arbiter : directed scenarios plus randomized traffic vs. reference
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ahb_mem_arbiter;
    localparam int N  = 3;
    localparam int WA = 32;
    localparam int WD = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;

    ahb_mem_arbiter_if #(.N_MASTERS(N), .W_ADDR(WA), .W_DATA(WD)) bus ();
    ahb_mem_arbiter #(.N_MASTERS(N), .W_ADDR(WA), .W_DATA(WD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.m_htrans = '0; bus.m_haddr = '0; bus.m_hwrite = '0; bus.m_hsize = '0;
        bus.m_hexcl = '0; bus.m_hmastlock = '0; bus.m_hwdata = '0;
    endtask

    task automatic req(input int i, input logic [31:0] a, input logic w, input logic x, input logic l);
        bus.m_htrans[2*i +: 2] = 2'b10; bus.m_haddr[WA*i +: WA] = a; bus.m_hwrite[i] = w;
        bus.m_hsize[3*i +: 3] = 3'd2; bus.m_hexcl[i] = x; bus.m_hmastlock[i] = l;
    endtask

    task automatic drop(input int i);
        bus.m_htrans[2*i +: 2] = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_all();
        bus.s_hready_resp = 1'b1; bus.s_hrdata = '0; bus.s_hresp = 1'b0; bus.s_hexokay = 1'b1;
        repeat (2) next();
        rst_n = 1'b1;
        next();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        bus.s_hready_resp = 1'b1; bus.s_hrdata = '1; bus.s_hresp = 1'b1; bus.s_hexokay = 1'b0;
        #12;
        tests++; if (bus.m_hready !== {N{1'b1}}) begin failed++; $display("FAIL rst_m_hready got=%b exp=%b", bus.m_hready, {N{1'b1}}); end
        tests++; if (bus.m_hrdata !== '0) begin failed++; $display("FAIL rst_m_hrdata got=%h exp=0", bus.m_hrdata); end
        tests++; if (bus.m_hresp !== '0) begin failed++; $display("FAIL rst_m_hresp got=%b exp=0", bus.m_hresp); end
        tests++; if (bus.m_hexokay !== {N{1'b1}}) begin failed++; $display("FAIL rst_m_hexokay got=%b exp=%b", bus.m_hexokay, {N{1'b1}}); end
        tests++; if (bus.s_htrans !== 2'b00) begin failed++; $display("FAIL rst_s_htrans got=%b exp=00", bus.s_htrans); end
        tests++; if (bus.s_haddr !== '0) begin failed++; $display("FAIL rst_s_haddr got=%h exp=0", bus.s_haddr); end
        tests++; if (bus.s_hmaster !== 8'd0) begin failed++; $display("FAIL rst_s_hmaster got=%0d exp=0", bus.s_hmaster); end
        tests++; if (bus.proto_err !== 1'b0) begin failed++; $display("FAIL rst_proto_err got=%b exp=0", bus.proto_err); end
    endtask

    task automatic test_single_read();
        do_reset();
        req(0, 32'h100, 1'b0, 1'b0, 1'b0);
        #1;
        tests++; if (bus.m_hready[0] !== 1'b1) begin failed++; $display("FAIL rd_accept got=%b exp=1", bus.m_hready[0]); end
        next(); drop(0); bus.s_hrdata = 32'hCAFE0001; #1;
        tests++; if (bus.s_htrans !== 2'b10) begin failed++; $display("FAIL rd_htrans got=%b exp=10", bus.s_htrans); end
        tests++; if (bus.s_haddr !== 32'h100) begin failed++; $display("FAIL rd_haddr got=%h exp=100", bus.s_haddr); end
        tests++; if (bus.s_hmaster !== 8'd0) begin failed++; $display("FAIL rd_hmaster got=%0d exp=0", bus.s_hmaster); end
        tests++; if (bus.m_hready[0] !== 1'b0) begin failed++; $display("FAIL rd_wait got=%b exp=0", bus.m_hready[0]); end
        next(); #1;
        tests++; if (bus.m_hready[0] !== 1'b1) begin failed++; $display("FAIL rd_done got=%b exp=1", bus.m_hready[0]); end
        tests++; if (bus.m_hrdata[31:0] !== 32'hCAFE0001) begin failed++; $display("FAIL rd_data got=%h exp=cafe0001", bus.m_hrdata[31:0]); end
        next();
    endtask

    task automatic test_simultaneous();
        do_reset();
        req(0, 32'h300, 1'b0, 1'b0, 1'b0); req(1, 32'h400, 1'b0, 1'b0, 1'b0);
        next(); idle_all(); #1;
        tests++; if (bus.s_hmaster !== 8'd0 || bus.s_haddr !== 32'h300) begin failed++; $display("FAIL sim_first got=%0d/%h exp=0/300", bus.s_hmaster, bus.s_haddr); end
        tests++; if (bus.m_hready[1] !== 1'b0) begin failed++; $display("FAIL sim_m1_wait_a got=%b exp=0", bus.m_hready[1]); end
        next(); #1;
        tests++; if (bus.m_hready[1:0] !== 2'b01) begin failed++; $display("FAIL sim_m0_done got=%b exp=01", bus.m_hready[1:0]); end
        next(); #1;
        tests++; if (bus.m_hready[1] !== 1'b0 || bus.s_htrans !== 2'b00) begin failed++; $display("FAIL sim_gap got=%b/%b exp=0/00", bus.m_hready[1], bus.s_htrans); end
        next(); #1;
        tests++; if (bus.s_htrans !== 2'b10 || bus.s_hmaster !== 8'd1 || bus.s_haddr !== 32'h400) begin failed++; $display("FAIL sim_second got=%b/%0d/%h exp=10/1/400", bus.s_htrans, bus.s_hmaster, bus.s_haddr); end
        next(); #1;
        tests++; if (bus.m_hready[1] !== 1'b1) begin failed++; $display("FAIL sim_m1_done got=%b exp=1", bus.m_hready[1]); end
        next();
    endtask

    task automatic test_write_stall();
        do_reset();
        req(0, 32'h200, 1'b1, 1'b0, 1'b0);
        next(); drop(0); req(1, 32'h500, 1'b0, 1'b0, 1'b0);
        bus.m_hwdata[31:0] = 32'hDEADBEEF; bus.s_hready_resp = 1'b0; #1;
        tests++; if (bus.s_hwrite !== 1'b1 || bus.s_hmaster !== 8'd0) begin failed++; $display("FAIL wr_addr got=%b/%0d exp=1/0", bus.s_hwrite, bus.s_hmaster); end
        tests++; if (bus.m_hready[1] !== 1'b1) begin failed++; $display("FAIL wr_m1_accept got=%b exp=1", bus.m_hready[1]); end
        next(); drop(1);
        for (int d = 1; d <= 6; d++) begin
            bus.s_hready_resp = (d == 6); #1;
            tests++; if (bus.s_hwdata !== 32'hDEADBEEF) begin failed++; $display("FAIL wr_hwdata_%0d got=%h exp=deadbeef", d, bus.s_hwdata); end
            tests++; if (bus.m_hready[1:0] !== {1'b0, d == 6}) begin failed++; $display("FAIL wr_hready_%0d got=%b exp=%b", d, bus.m_hready[1:0], {1'b0, d == 6}); end
            next();
        end
        #1;
        tests++; if (bus.s_htrans !== 2'b00) begin failed++; $display("FAIL wr_gap got=%b exp=00", bus.s_htrans); end
        next(); #1;
        tests++; if (bus.s_htrans !== 2'b10 || bus.s_hmaster !== 8'd1) begin failed++; $display("FAIL wr_next got=%b/%0d exp=10/1", bus.s_htrans, bus.s_hmaster); end
        next();
    endtask

    task automatic test_lock();
        int grants[$];
        int m1_left;
        bit m0_sent;
        int exp_g[4] = '{1, 1, 1, 0};
        do_reset();
        m1_left = 3; m0_sent = 1'b0;
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            if (bus.s_htrans == 2'b10) grants.push_back(int'(bus.s_hmaster));
            if (!m0_sent && m1_left < 3) begin req(0, 32'h700, 1'b0, 1'b0, 1'b0); m0_sent = 1'b1; end
            else drop(0);
            if (m1_left > 0 && bus.m_hready[1]) begin
                req(1, 32'h600 + 32'(m1_left), 1'b0, 1'b0, m1_left > 1); m1_left--;
            end else drop(1);
            #1;
            next();
        end
        idle_all();
        tests++; if (grants.size() != 4) begin failed++; $display("FAIL lock_grant_count got=%0d exp=4", grants.size()); end
        for (int k = 0; k < 4 && k < grants.size(); k++) begin
            tests++; if (grants[k] != exp_g[k]) begin failed++; $display("FAIL lock_grant_%0d got=%0d exp=%0d", k, grants[k], exp_g[k]); end
        end
        next();
    endtask

    task automatic test_excl();
        do_reset();
        req(1, 32'h800, 1'b0, 1'b1, 1'b0);
        next(); drop(1); #1;
        tests++; if (bus.s_hexcl !== 1'b1 || bus.s_hmaster !== 8'd1) begin failed++; $display("FAIL ex_addr got=%b/%0d exp=1/1", bus.s_hexcl, bus.s_hmaster); end
        next(); bus.s_hexokay = 1'b0; #1;
        tests++; if (bus.m_hexokay !== 3'b101) begin failed++; $display("FAIL ex_hexokay got=%b exp=101", bus.m_hexokay); end
        tests++; if (bus.m_hready[1] !== 1'b1) begin failed++; $display("FAIL ex_done got=%b exp=1", bus.m_hready[1]); end
        next(); bus.s_hexokay = 1'b1;
    endtask

    task automatic test_proto_and_reset();
        do_reset();
        bus.m_htrans[1:0] = 2'b11;
        next(); idle_all(); #1;
        tests++; if (bus.proto_err !== 1'b1) begin failed++; $display("FAIL pe_flag got=%b exp=1", bus.proto_err); end
        tests++; if (bus.s_htrans !== 2'b00 || bus.m_hready[0] !== 1'b1) begin failed++; $display("FAIL pe_nocap got=%b/%b exp=00/1", bus.s_htrans, bus.m_hready[0]); end
        next(); #1;
        tests++; if (bus.s_htrans !== 2'b00) begin failed++; $display("FAIL pe_noxfer got=%b exp=00", bus.s_htrans); end
        req(0, 32'h900, 1'b0, 1'b0, 1'b0);
        next(); drop(0);
        next(); bus.s_hready_resp = 1'b0; bus.s_hrdata = 32'hAAAA5555; #1;
        tests++; if (bus.m_hready[0] !== 1'b0) begin failed++; $display("FAIL mr_in_data got=%b exp=0", bus.m_hready[0]); end
        rst_n = 1'b0; #1;
        tests++; if (bus.m_hready !== {N{1'b1}} || bus.m_hrdata !== '0 || bus.m_hexokay !== {N{1'b1}}) begin failed++; $display("FAIL mr_master_side got=%b/%h/%b exp=111/0/111", bus.m_hready, bus.m_hrdata, bus.m_hexokay); end
        tests++; if (bus.s_htrans !== 2'b00 || bus.s_haddr !== '0 || bus.s_hmaster !== 8'd0 || bus.proto_err !== 1'b0) begin failed++; $display("FAIL mr_slave_side got=%b/%h/%0d/%b exp=00/0/0/0", bus.s_htrans, bus.s_haddr, bus.s_hmaster, bus.proto_err); end
        next(); rst_n = 1'b1; bus.s_hready_resp = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next();
            tests++; if (bus.s_htrans !== 2'b00 || bus.m_hrdata !== '0) begin failed++; $display("FAIL mr_abandon_%0d got=%b/%h exp=00/0", c, bus.s_htrans, bus.m_hrdata); end
        end
    endtask

    // Reference: pending set, round-robin pointer, lock owner, one transfer in flight
    task automatic test_random();
        logic [N-1:0]  pm, er, acc;
        logic [31:0]   ra [N];
        logic [31:0]   rd [N];
        logic [2:0]    rs [N];
        logic          rw [N], rx [N], rl [N];
        logic [31:0]   ca, cd, sdat, a;
        logic [2:0]    cs, sz;
        logic          cw, cx, cl, w, x, l, sresp, sok;
        int            last, own, lkm, j;
        bit            infl, dph, lk, got;
        do_reset();
        pm = '0; last = N - 1; own = 0; lkm = 0; infl = 0; dph = 0; lk = 0;
        ca = '0; cd = '0; cs = '0; cw = 0; cx = 0; cl = 0;
        for (int i = 0; i < N; i++) begin ra[i] = '0; rd[i] = '0; rs[i] = '0; rw[i] = 0; rx[i] = 0; rl[i] = 0; end
        for (int c = 0; c < 3000; c++) begin
            bus.s_hready_resp = ($urandom_range(0, 3) != 0);
            sdat = $urandom; sresp = 1'($urandom); sok = 1'($urandom);
            bus.s_hrdata = sdat; bus.s_hresp = sresp; bus.s_hexokay = sok;
            acc = '0;
            for (int i = 0; i < N; i++) begin
                er[i] = !(pm[i] || (infl && own == i)) || (infl && dph && own == i && bus.s_hready_resp);
                a = $urandom; w = 1'($urandom); sz = 3'($urandom); x = 1'($urandom); l = ($urandom_range(0, 2) == 0);
                bus.m_haddr[WA*i +: WA] = a; bus.m_hwrite[i] = w; bus.m_hsize[3*i +: 3] = sz;
                bus.m_hexcl[i] = x; bus.m_hmastlock[i] = l;
                bus.m_hwdata[WD*i +: WD] = (infl && dph && own == i) ? cd : $urandom;
                if ($urandom_range(0, 1) == 1) begin
                    bus.m_htrans[2*i +: 2] = 2'b10;
                    if (er[i]) begin acc[i] = 1'b1; ra[i] = a; rw[i] = w; rs[i] = sz; rx[i] = x; rl[i] = l; rd[i] = $urandom; end
                end else bus.m_htrans[2*i +: 2] = 2'b00;
            end
            #1;
            tests++; if (bus.m_hready !== er) begin failed++; $display("FAIL rnd_hready c=%0d got=%b exp=%b", c, bus.m_hready, er); end
            tests++; if (bus.s_hready !== bus.s_hready_resp) begin failed++; $display("FAIL rnd_s_hready c=%0d got=%b exp=%b", c, bus.s_hready, bus.s_hready_resp); end
            if (infl && !dph) begin
                tests++; if ({bus.s_htrans, bus.s_haddr, bus.s_hwrite, bus.s_hsize, bus.s_hexcl, bus.s_hmastlock, bus.s_hmaster} !== {2'b10, ca, cw, cs, cx, cl, 8'(own)})
                    begin failed++; $display("FAIL rnd_addr c=%0d got=%b/%h/%0d exp=10/%h/%0d", c, bus.s_htrans, bus.s_haddr, bus.s_hmaster, ca, own); end
            end else begin
                tests++; if (bus.s_htrans !== 2'b00) begin failed++; $display("FAIL rnd_htrans c=%0d got=%b exp=00", c, bus.s_htrans); end
            end
            if (infl && dph) begin
                tests++; if (bus.s_hwdata !== cd) begin failed++; $display("FAIL rnd_hwdata c=%0d got=%h exp=%h", c, bus.s_hwdata, cd); end
            end
            for (int i = 0; i < N; i++) begin
                got = infl && dph && own == i;
                tests++; if ({bus.m_hrdata[WD*i +: WD], bus.m_hresp[i], bus.m_hexokay[i]} !== (got ? {sdat, sresp, sok} : {32'h0, 1'b0, 1'b1}))
                    begin failed++; $display("FAIL rnd_route c=%0d m=%0d got=%h/%b/%b", c, i, bus.m_hrdata[WD*i +: WD], bus.m_hresp[i], bus.m_hexokay[i]); end
            end
            pm = pm | acc;
            if (infl) begin
                if (!dph) dph = 1;
                else if (bus.s_hready_resp) begin infl = 0; lk = cl; lkm = own; end
            end else if (bus.s_hready_resp && (|pm)) begin
                j = -1;
                if (lk && pm[lkm]) j = lkm;
                else for (int k = 1; k <= N; k++) if (j < 0 && pm[(last + k) % N]) j = (last + k) % N;
                infl = 1; dph = 0; own = j; last = j; pm[j] = 1'b0;
                ca = ra[j]; cw = rw[j]; cs = rs[j]; cx = rx[j]; cl = rl[j]; cd = rd[j];
            end
            next();
        end
        idle_all();
    endtask

    initial begin
        idle_all();
        bus.s_hready_resp = 1'b1; bus.s_hrdata = '0; bus.s_hresp = 1'b0; bus.s_hexokay = 1'b1;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write_stall();
        test_lock();
        test_excl();
        test_proto_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout tests=%0d failed=%0d", tests, failed);
        $fatal(1, "simulation time limit reached");
    end
endmodule

`default_nettype wire
